dsp_multadd_acc_nlane: RTL and testbench

Parametrised successor to the fixed dual-lane 10x9 multiply-add DSP wrapper. It is a soft, pipelined N-lane multiply-add-accumulate block with per-lane coefficient banks, optional input and output registers, and a valid-tracked pipeline. It adds arithmetic shift-right with rounding, signed/unsigned saturation and an overflow flag. It sits in the DSP mapping layer, where it serves as the reference/fallback implementation for multi-lane MAC configurations that the hard DSP cannot cover.

---
 rtl/dsp_multadd_acc_nlane.sv | 188 ++++++++++++++++++
 tb/tb_dsp_multadd_acc_nlane.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_multadd_acc_nlane.sv
// N-lane pipelined multiply-add-accumulate with per-lane coefficient banks,
// optional input/output registers, round/shift, saturation and overflow flag.
module dsp_multadd_acc_nlane #(
  parameter int    NUM_LANES     = 2,
  parameter int    A_WIDTH       = 10,
  parameter int    B_WIDTH       = 9,
  parameter int    ACC_WIDTH     = 24,
  parameter int    Z_WIDTH       = 19,
  parameter string INPUT_REG_EN  = "TRUE",
  parameter string OUTPUT_REG_EN = "TRUE",
  parameter logic [NUM_LANES*4*A_WIDTH-1:0] COEFF_INIT = '0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           VALID_IN,
  input  logic [NUM_LANES*A_WIDTH-1:0]   A,
  input  logic [NUM_LANES*B_WIDTH-1:0]   B,
  input  logic [2:0]                     FEEDBACK,
  input  logic                           LOAD_ACC,
  input  logic                           SUBTRACT,
  input  logic                           UNSIGNED_A,
  input  logic                           UNSIGNED_B,
  input  logic [$clog2(ACC_WIDTH)-1:0]   SHIFT_RIGHT,
  input  logic                           ROUND,
  input  logic                           SATURATE,
  output logic [Z_WIDTH-1:0]             Z,
  output logic                           VALID_OUT,
  output logic [NUM_LANES*B_WIDTH-1:0]   DLY_B,
  output logic                           OVERFLOW
);
  localparam bit IN_REG  = (INPUT_REG_EN == "TRUE");
  localparam bit OUT_REG = (OUTPUT_REG_EN == "TRUE");
  localparam int SH_W    = $clog2(ACC_WIDTH);
  localparam int PW      = A_WIDTH + B_WIDTH + 2;
  localparam int RW      = ACC_WIDTH + 1;

  typedef struct packed {
    logic            valid;
    logic [2:0]      feedback;
    logic            load_acc;
    logic            subtract;
    logic            unsigned_a;
    logic            unsigned_b;
    logic [SH_W-1:0] shift;
    logic            round;
    logic            saturate;
  } ctrl_t;

  ctrl_t                         ctrl_in, ctrl_s0;
  logic [NUM_LANES*A_WIDTH-1:0]  a_s0;
  logic [NUM_LANES*B_WIDTH-1:0]  b_s0;
  logic [NUM_LANES*B_WIDTH-1:0]  dly_b_reg;

  assign ctrl_in = '{valid: VALID_IN, feedback: FEEDBACK, load_acc: LOAD_ACC,
                     subtract: SUBTRACT, unsigned_a: UNSIGNED_A, unsigned_b: UNSIGNED_B,
                     shift: SHIFT_RIGHT, round: ROUND, saturate: SATURATE};

  always_ff @(posedge CLK) begin
    if (RESET) dly_b_reg <= '0;
    else       dly_b_reg <= B;
  end
  assign DLY_B = dly_b_reg;

  generate
    if (IN_REG) begin : g_in_reg
      ctrl_t                        ctrl_reg;
      logic [NUM_LANES*A_WIDTH-1:0] a_reg;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          ctrl_reg <= '0;
          a_reg    <= '0;
        end else begin
          ctrl_reg <= ctrl_in;
          a_reg    <= A;
        end
      end
      assign ctrl_s0 = ctrl_reg;
      assign a_s0    = a_reg;
      assign b_s0    = dly_b_reg;
    end else begin : g_in_comb
      assign ctrl_s0 = ctrl_in;
      assign a_s0    = A;
      assign b_s0    = B;
    end
  endgenerate

  // Per-lane products, extended one bit so signed/unsigned share one signed multiply.
  logic [ACC_WIDTH-1:0] prod [NUM_LANES];
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [A_WIDTH-1:0]        coeff [4];
      logic [A_WIDTH-1:0]        op_a;
      logic [B_WIDTH-1:0]        op_b;
      logic signed [A_WIDTH:0]   a_x;
      logic signed [B_WIDTH:0]   b_x;
      logic signed [PW-1:0]      p;
      for (genvar gk = 0; gk < 4; gk++) begin : g_coeff
        assign coeff[gk] = COEFF_INIT[(gi*4+gk)*A_WIDTH +: A_WIDTH];
      end
      assign op_a = ctrl_s0.feedback[2] ? coeff[ctrl_s0.feedback[1:0]]
                                        : a_s0[gi*A_WIDTH +: A_WIDTH];
      assign op_b = b_s0[gi*B_WIDTH +: B_WIDTH];
      assign a_x  = {~ctrl_s0.unsigned_a & op_a[A_WIDTH-1], op_a};
      assign b_x  = {~ctrl_s0.unsigned_b & op_b[B_WIDTH-1], op_b};
      assign p    = a_x * b_x;
      assign prod[gi] = ACC_WIDTH'(p);
    end
  endgenerate

  logic [ACC_WIDTH-1:0] sum, base, acc_next;
  logic [ACC_WIDTH-1:0] acc_reg;
  always_comb begin
    sum = '0;
    for (int l = 0; l < NUM_LANES; l++) sum = sum + prod[l];
    base     = ctrl_s0.load_acc ? '0 : acc_reg;
    acc_next = ctrl_s0.subtract ? base - sum : base + sum;
  end

  // Output-path controls travel with the beat and only change on valid beats,
  // so an unregistered output stage still holds its value between beats.
  logic            v1_reg, dom_u_reg, round_reg, sat_reg;
  logic [SH_W-1:0] shift_reg;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v1_reg    <= 1'b0;
      acc_reg   <= '0;
      dom_u_reg <= 1'b0;
      round_reg <= 1'b0;
      sat_reg   <= 1'b0;
      shift_reg <= '0;
    end else begin
      v1_reg <= ctrl_s0.valid;
      if (ctrl_s0.valid) begin
        acc_reg   <= acc_next;
        dom_u_reg <= ctrl_s0.unsigned_a & ctrl_s0.unsigned_b;
        round_reg <= ctrl_s0.round;
        sat_reg   <= ctrl_s0.saturate;
        shift_reg <= ctrl_s0.shift;
      end
    end
  end

  logic signed [RW-1:0] acc_x, rnd, r;
  logic [RW-1:0]        shifted;
  logic                 fits;
  logic [Z_WIDTH-1:0]   sat_val, z_calc;
  always_comb begin
    acc_x   = {~dom_u_reg & acc_reg[ACC_WIDTH-1], acc_reg};
    rnd     = (round_reg && shift_reg != '0) ? (RW'(1) << (shift_reg - SH_W'(1))) : '0;
    r       = acc_x + rnd;
    shifted = dom_u_reg ? (r >> shift_reg) : (r >>> shift_reg);
    if (dom_u_reg) begin
      fits    = ~|shifted[RW-1:Z_WIDTH];
      sat_val = '1;
    end else begin
      fits    = (&shifted[RW-1:Z_WIDTH-1]) | ~(|shifted[RW-1:Z_WIDTH-1]);
      sat_val = shifted[RW-1] ? {1'b1, {(Z_WIDTH-1){1'b0}}} : {1'b0, {(Z_WIDTH-1){1'b1}}};
    end
    z_calc = (!fits && sat_reg) ? sat_val : shifted[Z_WIDTH-1:0];
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [Z_WIDTH-1:0] z_reg;
      logic               ovf_reg, vout_reg;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          z_reg    <= '0;
          ovf_reg  <= 1'b0;
          vout_reg <= 1'b0;
        end else begin
          vout_reg <= v1_reg;
          if (v1_reg) begin
            z_reg   <= z_calc;
            ovf_reg <= ~fits;
          end
        end
      end
      assign Z         = z_reg;
      assign OVERFLOW  = ovf_reg;
      assign VALID_OUT = vout_reg;
    end else begin : g_out_comb
      assign Z         = z_calc;
      assign OVERFLOW  = ~fits;
      assign VALID_OUT = v1_reg;
    end
  endgenerate
endmodule

// File: tb/tb_dsp_multadd_acc_nlane.sv
// Directed-vector bench for dsp_multadd_acc_nlane at default parameters
// (coefficient bank preloaded so lane0 idx2=127, lane1 idx2=0).
module tb_dsp_multadd_acc_nlane;
  localparam int NL = 2, AW = 10, BW = 9, ACCW = 24, ZW = 19;
  localparam logic [NL*4*AW-1:0] COEFF =
    (80'(127) << 20) | (80'(9) << 30) | (80'(5) << 50);

  logic              CLK = 1'b0;
  logic              RESET, VALID_IN, LOAD_ACC, SUBTRACT, UNSIGNED_A, UNSIGNED_B, ROUND, SATURATE;
  logic [NL*AW-1:0]  A;
  logic [NL*BW-1:0]  B;
  logic [2:0]        FEEDBACK;
  logic [4:0]        SHIFT_RIGHT;
  logic [ZW-1:0]     Z;
  logic              VALID_OUT, OVERFLOW;
  logic [NL*BW-1:0]  DLY_B;

  int vectors = 0;
  int miscompares = 0;
  logic [ZW-1:0] zq[$];
  logic          oq[$];

  dsp_multadd_acc_nlane #(.COEFF_INIT(COEFF)) dut (
    .CLK(CLK), .RESET(RESET), .VALID_IN(VALID_IN), .A(A), .B(B), .FEEDBACK(FEEDBACK),
    .LOAD_ACC(LOAD_ACC), .SUBTRACT(SUBTRACT), .UNSIGNED_A(UNSIGNED_A), .UNSIGNED_B(UNSIGNED_B),
    .SHIFT_RIGHT(SHIFT_RIGHT), .ROUND(ROUND), .SATURATE(SATURATE),
    .Z(Z), .VALID_OUT(VALID_OUT), .DLY_B(DLY_B), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Record every output beat; tests compare the recorded stream.
  always @(negedge CLK) begin
    if (VALID_OUT === 1'b1) begin
      zq.push_back(Z);
      oq.push_back(OVERFLOW);
      $display("beat out: Z=%h OVERFLOW=%b", Z, OVERFLOW);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic beat(input logic [AW-1:0] a0, a1, input logic [BW-1:0] b0, b1,
                      input logic [2:0] fb, input logic ld, sub, us,
                      input logic [4:0] sh, input logic rnd, sat);
    @(negedge CLK);
    RESET = 1'b0; VALID_IN = 1'b1;
    A = {a1, a0}; B = {b1, b0}; FEEDBACK = fb;
    LOAD_ACC = ld; SUBTRACT = sub; UNSIGNED_A = us; UNSIGNED_B = us;
    SHIFT_RIGHT = sh; ROUND = rnd; SATURATE = sat;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      VALID_IN = 1'b0;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; VALID_IN = 1'b1;
    A = 20'($urandom); B = 18'($urandom); FEEDBACK = 3'($urandom);
    LOAD_ACC = 1'b1; SUBTRACT = 1'($urandom); UNSIGNED_A = 1'b0; UNSIGNED_B = 1'b0;
    SHIFT_RIGHT = 5'($urandom); ROUND = 1'($urandom); SATURATE = 1'($urandom);
    repeat (2) @(negedge CLK);
    vectors++; if (Z !== '0) begin miscompares++; $display("FAIL reset_z: got %h expected 0", Z); end
    vectors++; if (VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", VALID_OUT); end
    vectors++; if (DLY_B !== '0) begin miscompares++; $display("FAIL reset_dly_b: got %h expected 0", DLY_B); end
    vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", OVERFLOW); end
    RESET = 1'b0; VALID_IN = 1'b0;
    zq.delete(); oq.delete();
    idle(5);
    vectors++; if (zq.size() != 0) begin miscompares++; $display("FAIL reset_spurious: %0d output beats, expected 0", zq.size()); end
    $display("test_reset done");
  endtask

  task automatic test_multadd;
    zq.delete(); oq.delete();
    beat(10'd3, 10'd5, 9'd4, 9'd6, 3'b000, 1, 0, 0, 5'd0, 0, 0);
    idle(1);
    vectors++; if (DLY_B !== {9'd6, 9'd4}) begin miscompares++; $display("FAIL multadd_dly_b: got %h expected %h", DLY_B, {9'd6, 9'd4}); end
    idle(1);
    vectors++; if (VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL multadd_early: VALID_OUT=%b at cycle 2, expected 0", VALID_OUT); end
    idle(1);
    vectors++; if (VALID_OUT !== 1'b1) begin miscompares++; $display("FAIL multadd_latency: VALID_OUT=%b at cycle 3, expected 1", VALID_OUT); end
    vectors++; if (Z !== 19'd42) begin miscompares++; $display("FAIL multadd_z: got %0d expected 42", Z); end
    vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL multadd_ovf: got %b expected 0", OVERFLOW); end
    idle(1);
    vectors++; if (VALID_OUT !== 1'b0) begin miscompares++; $display("FAIL multadd_pulse: VALID_OUT=%b at cycle 4, expected 0", VALID_OUT); end
    vectors++; if (Z !== 19'd42) begin miscompares++; $display("FAIL multadd_hold: got %0d expected 42", Z); end
    $display("test_multadd done");
  endtask

  task automatic test_accum_gap;
    logic [ZW-1:0] exp_z [4] = '{19'd5, 19'd10, 19'd15, 19'd20};
    zq.delete(); oq.delete();
    beat(10'd1, 10'd1, 9'd2, 9'd3, 3'b000, 1, 0, 0, 5'd0, 0, 0);
    beat(10'd1, 10'd1, 9'd2, 9'd3, 3'b000, 0, 0, 0, 5'd0, 0, 0);
    @(negedge CLK); VALID_IN = 1'b0; LOAD_ACC = 1'b1;
    beat(10'd1, 10'd1, 9'd2, 9'd3, 3'b000, 0, 0, 0, 5'd0, 0, 0);
    beat(10'd1, 10'd1, 9'd2, 9'd3, 3'b000, 0, 0, 0, 5'd0, 0, 0);
    idle(6);
    vectors++; if (zq.size() != 4) begin miscompares++; $display("FAIL accum_count: %0d beats, expected 4", zq.size()); end
    for (int i = 0; i < 4 && i < zq.size(); i++) begin
      vectors++;
      if (zq[i] !== exp_z[i]) begin miscompares++; $display("FAIL accum_z[%0d]: got %0d expected %0d", i, zq[i], exp_z[i]); end
    end
    $display("test_accum_gap done");
  endtask

  task automatic test_coeff;
    logic [ZW-1:0] exp_z [2] = '{19'h7FF02, 19'd254};
    zq.delete(); oq.delete();
    beat(10'd100, 10'd100, 9'h1FE, 9'd7, 3'b110, 1, 0, 0, 5'd0, 0, 0);
    beat(10'd100, 10'd100, 9'h1FE, 9'd7, 3'b110, 1, 1, 0, 5'd0, 0, 0);
    idle(6);
    vectors++; if (zq.size() != 2) begin miscompares++; $display("FAIL coeff_count: %0d beats, expected 2", zq.size()); end
    for (int i = 0; i < 2 && i < zq.size(); i++) begin
      vectors++;
      if (zq[i] !== exp_z[i]) begin miscompares++; $display("FAIL coeff_z[%0d]: got %h expected %h", i, zq[i], exp_z[i]); end
    end
    $display("test_coeff done");
  endtask

  task automatic test_shift_round;
    logic [ZW-1:0] exp_z [5] = '{19'd6, 19'd5, 19'h7FFFA, 19'd23, 19'h7FFFF};
    logic          exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    zq.delete(); oq.delete();
    beat(10'd23,   10'd0,    9'd1,   9'd0,   3'b000, 1, 0, 0, 5'd2, 1, 0);
    beat(10'd23,   10'd0,    9'd1,   9'd0,   3'b000, 1, 0, 0, 5'd2, 0, 0);
    beat(10'h3E9,  10'd0,    9'd1,   9'd0,   3'b000, 1, 0, 0, 5'd2, 1, 0);
    beat(10'd23,   10'd0,    9'd1,   9'd0,   3'b000, 1, 0, 0, 5'd0, 1, 0);
    beat(10'd1023, 10'd1023, 9'd511, 9'd511, 3'b000, 1, 0, 1, 5'd0, 0, 1);
    idle(6);
    vectors++; if (zq.size() != 5) begin miscompares++; $display("FAIL shift_count: %0d beats, expected 5", zq.size()); end
    for (int i = 0; i < 5 && i < zq.size(); i++) begin
      vectors++;
      if (zq[i] !== exp_z[i] || oq[i] !== exp_o[i]) begin
        miscompares++;
        $display("FAIL shift_z[%0d]: got Z=%h OVERFLOW=%b expected Z=%h OVERFLOW=%b", i, zq[i], oq[i], exp_z[i], exp_o[i]);
      end
    end
    $display("test_shift_round done");
  endtask

  task automatic test_saturate;
    logic [ZW-1:0] exp_z [5] = '{19'd260610, 19'h3FFFF, 19'h7F404, 19'(-260610), 19'h40000};
    logic          exp_o [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    zq.delete(); oq.delete();
    beat(10'd511, 10'd511, 9'd255, 9'd255, 3'b000, 1, 0, 0, 5'd0, 0, 1);
    beat(10'd511, 10'd511, 9'd255, 9'd255, 3'b000, 0, 0, 0, 5'd0, 0, 1);
    beat(10'd0,   10'd0,   9'd0,   9'd0,   3'b000, 0, 0, 0, 5'd0, 0, 0);
    beat(10'd511, 10'd511, 9'd255, 9'd255, 3'b000, 1, 1, 0, 5'd0, 0, 1);
    beat(10'd511, 10'd511, 9'd255, 9'd255, 3'b000, 0, 1, 0, 5'd0, 0, 1);
    idle(6);
    vectors++; if (zq.size() != 5) begin miscompares++; $display("FAIL sat_count: %0d beats, expected 5", zq.size()); end
    for (int i = 0; i < 5 && i < zq.size(); i++) begin
      vectors++;
      if (zq[i] !== exp_z[i] || oq[i] !== exp_o[i]) begin
        miscompares++;
        $display("FAIL sat_z[%0d]: got Z=%h OVERFLOW=%b expected Z=%h OVERFLOW=%b", i, zq[i], oq[i], exp_z[i], exp_o[i]);
      end
    end
    $display("test_saturate done");
  endtask

  task automatic test_mid_reset;
    zq.delete(); oq.delete();
    beat(10'd3, 10'd5, 9'd4, 9'd6, 3'b000, 1, 0, 0, 5'd0, 0, 0);
    @(negedge CLK); RESET = 1'b1; VALID_IN = 1'b0;
    @(negedge CLK); RESET = 1'b0;
    idle(5);
    vectors++; if (zq.size() != 0) begin miscompares++; $display("FAIL midreset_drop: %0d beats, expected 0", zq.size()); end
    vectors++; if (Z !== '0) begin miscompares++; $display("FAIL midreset_z: got %h expected 0", Z); end
    vectors++; if (OVERFLOW !== 1'b0) begin miscompares++; $display("FAIL midreset_ovf: got %b expected 0", OVERFLOW); end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_multadd();
    test_accum_gap();
    test_coeff();
    test_shift_round();
    test_saturate();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
